fifo_merge_arbiter: RTL
=======================

FIFO_MERGE_ARBITER -- requirements
Module: fifo_merge_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 70: payload width of both sources and the output.
REQ-002 Parameter CNT_WIDTH, default 16: width of each per-source grant counter.
REQ-003 Ports, clock and reset first:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  source A FIFO non-empty
- a_data  in  DATA_WIDTH  source A FIFO head entry
- a_pop  out  1  dequeue source A head this cycle
- b_valid  in  1  source B FIFO non-empty
- b_data  in  DATA_WIDTH  source B FIFO head entry
- b_pop  out  1  dequeue source B head this cycle
- out_valid  out  1  output register holds an entry
- out_data  out  DATA_WIDTH  registered payload
- out_src  out  1  origin of out_data: 0=A, 1=B
- out_ack  in  1  consumer accepts out_data this cycle
- a_grants  out  CNT_WIDTH  count of A entries accepted
- b_grants  out  CNT_WIDTH  count of B entries accepted

Function
REQ-004 Sources are the read side of single-clock FIFOs. The head entry is valid while *_valid=1 and is removed on the clock edge where *_pop=1.
REQ-005 a_pop and b_pop SHALL be combinational. At most one SHALL be high in any cycle. Neither SHALL be high unless its *_valid is high.
REQ-006 Load enable: load = ~out_valid | out_ack.
REQ-007 A pop SHALL occur only when load=1 and at least one source is valid.
REQ-008 Arbitration is round-robin using the register last_src, where 0 means A was last granted:
- only A valid -> grant A
- only B valid -> grant B
- both valid -> grant the source not equal to last_src
REQ-009 On a grant, at the same edge:
- out_data <= granted *_data
- out_src <= granted source
- out_valid <= 1
- last_src <= granted source
REQ-010 If out_ack=1 and no source is valid, out_valid SHALL be 0 on the next cycle and out_data/out_src SHALL hold their values.
REQ-011 If out_valid=1 and out_ack=0, out_data, out_src and out_valid SHALL hold, and no pop SHALL occur.
REQ-012 out_ack while out_valid=0 SHALL be ignored.
REQ-013 Throughput: one entry per cycle when the consumer acks every cycle.
REQ-014 Latency: data popped at edge N is presented on out_data after edge N, i.e. one cycle.
REQ-015 Grant counters: a_grants increments by 1 on each A pop and b_grants on each B pop. Each counter saturates at 2^CNT_WIDTH-1 and never wraps.
REQ-016 Every output entry SHALL correspond to exactly one pop. Per-source order SHALL be preserved. No entry SHALL be duplicated or dropped.

Reset
REQ-017 While rst=1:
- out_valid=0
- last_src=1 (so A wins the first tie)
- a_grants=0, b_grants=0
- a_pop=0, b_pop=0
REQ-018 out_data and out_src are not reset.
REQ-019 Reset asserted mid-transfer SHALL discard the held entry without a pop. Source FIFOs are reset by the same rst.
REQ-020 The first grant is possible in the first cycle after rst deasserts.

Verification
REQ-021 Reset, then a_valid=b_valid=1 continuously and out_ack=1:
- a_pop/b_pop alternate starting with A
- out_src sequence is 0,1,0,1
- a_grants=b_grants=2 after 4 pops
REQ-022 Only A valid with entries 0x1,0x2,0x3, out_ack held 0 for 3 cycles then 1:
- out_data=0x1 is held during the stall with no further pops
- after ack: 0x2, then 0x3 on consecutive cycles
REQ-023 out_valid=1 with out_ack=1 and both sources empty:
- next cycle out_valid=0
- a_pop=b_pop=0
REQ-024 Force a_grants to 2^CNT_WIDTH-2, then 3 A grants:
- a_grants stops at 2^CNT_WIDTH-1
- b_grants is unchanged
REQ-025 Assert rst for 1 cycle while out_valid=1 and out_ack=0:
- next cycle out_valid=0, counters=0
- with both sources valid, the first grant is A
REQ-026 Randomized valid/ack for 10k cycles with a scoreboard per source:
- no pop without valid
- never two pops in one cycle
- order is preserved
- grant difference between A and B is at most 1 while both are continuously valid

Source files
------------

// File: rtl/fifo_merge_arbiter.sv
// Merges two FIFO read ports into one registered output using round-robin
// arbitration, with saturating per-source grant counters.
module fifo_merge_arbiter #(
    parameter int DATA_WIDTH = 70,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_pop,
    input  logic                  b_valid,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_pop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_src,
    input  logic                  out_ack,
    output logic [CNT_WIDTH-1:0]  a_grants,
    output logic [CNT_WIDTH-1:0]  b_grants
);

    logic last_src;
    logic load;
    logic grant_a;
    logic grant_b;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == {CNT_WIDTH{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Grant decision: the output register can accept a new entry when empty or
    // being consumed; on a tie the source not granted last time wins.
    always_comb begin
        load    = ~out_valid | out_ack;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && load) begin
            if (a_valid && (!b_valid || last_src))
                grant_a = 1'b1;
            else if (b_valid)
                grant_b = 1'b1;
        end
    end

    assign a_pop = grant_a;
    assign b_pop = grant_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            last_src  <= 1'b1;
            a_grants  <= '0;
            b_grants  <= '0;
        end else if (grant_a) begin
            out_valid <= 1'b1;
            last_src  <= 1'b0;
            a_grants  <= sat_inc(a_grants);
        end else if (grant_b) begin
            out_valid <= 1'b1;
            last_src  <= 1'b1;
            b_grants  <= sat_inc(b_grants);
        end else if (out_ack) begin
            out_valid <= 1'b0;
        end
    end

    // Payload register is left unreset; it only matters while out_valid is set.
    always_ff @(posedge clk) begin
        if (grant_a || grant_b) begin
            out_data <= grant_b ? b_data : a_data;
            out_src  <= grant_b;
        end
    end

endmodule
